ac_e_register: RTL
==================

Name: ac_e_register

Overview:
- Accumulator/extension register unit that sits on the output side of the 16-bit ALU.
- Captures the ALU's Result and E outputs on command, or loads the accumulator directly from the data bus.
- Executes register-reference micro-ops (clear, complement, increment, multi-step rotate through E) and exposes skip-condition flags to the control unit.
- Multi-step rotates are sequenced internally with a busy/done handshake.

Parameters:
- WIDTH, 16, accumulator width; the ALU and data bus share this width. E is always 1 bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- alu_result  input  WIDTH  ALU Result bus
- alu_e  input  1  ALU E (carry-out) bit
- load_alu  input  1  capture alu_result into ac and alu_e into e
- ld_data  input  1  load ac from data_in; e unchanged
- data_in  input  WIDTH  data bus value
- op_valid  input  1  request micro-op op
- op  input  3  0 CLA, 1 CLE, 2 CMA, 3 CME, 4 CIR, 5 CIL, 6 INC, 7 NOP
- shamt  input  4  rotate step count minus 1 (CIR/CIL only)
- busy  output  1  rotate in progress; high exactly while state is SHIFT
- done  output  1  one-cycle pulse when a micro-op completes
- ac  output  WIDTH  accumulator
- e  output  1  extension bit
- ac_zero  output  1  ac == 0
- ac_neg  output  1  ac[WIDTH-1]
- e_zero  output  1  e == 0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: ac=0, e=0, done=0, state=IDLE, step counter=0. Flags therefore read ac_zero=1, ac_neg=0, e_zero=1, busy=0.
- Reset has top priority at every edge, including mid-rotate; an in-progress rotate is abandoned with no done pulse.
- Flags and busy are combinational from registered state; ac, e and done are registered.
- States are IDLE and SHIFT.
- In IDLE, priority is load_alu > ld_data > op_valid:
  - load_alu: ac<=alu_result, e<=alu_e, done<=1.
  - ld_data (no load_alu): ac<=data_in, e unchanged, done<=1.
  - op_valid, accepted only with no load this cycle; a lower-priority request is dropped, not queued.
    - CLA: ac<=0.
    - CLE: e<=0.
    - CMA: ac<=~ac.
    - CME: e<=~e.
    - INC: ac<=ac+1 modulo 2^WIDTH; e unchanged, including on wrap FFFF->0000.
    - NOP: no change.
    - All of the above set done<=1 at the accepting edge, so done is high the following cycle.
    - CIR/CIL: state<=SHIFT, cnt<=shamt, direction latched; ac and e are unchanged at the accept edge; done<=0.
- In SHIFT, each edge performs one rotate of the 17-bit word {e,ac}:
  - CIR: ac<={e,ac[15:1]}, e<=ac[0].
  - CIL: ac<={ac[14:0],e}, e<=ac[15].
  - If cnt==0: state<=IDLE, done<=1. Otherwise cnt<=cnt-1.
  - Total rotates = shamt+1 (1..16). busy is high for shamt+1 cycles. done pulses in the cycle after the final rotate.
- While busy, load_alu, ld_data and op_valid are ignored; the controller must wait for done.
- done is high for exactly one cycle per completed operation and is 0 in every cycle with no completion.
- A new request may be presented in the same cycle done is high; it is accepted normally.
- X/undefined op values cannot occur because op is fully decoded (3 bits, 8 codes).

Test Plan:
- Reset: assert reset for 2 cycles with load_alu=1 -> ac=0000, e=0, ac_zero=1, e_zero=1, busy=0, done=0.
- ALU capture: load_alu=1, alu_result=FFFF, alu_e=1 -> next cycle ac=FFFF, e=1, ac_neg=1, done=1 for one cycle. Then ld_data=1, data_in=1234 -> ac=1234, e=1 unchanged.
- Priority and drop: load_alu=1 (alu_result=00AA), ld_data=1 (data_in=5555), op_valid=1 op=CLA simultaneously -> ac=00AA; CLA not executed; single done pulse.
- Rotate left: ac=8000, e=0, CIL shamt=0 -> busy for 1 cycle, then ac=0000, e=1, done pulse. Accept-to-done is 2 cycles.
- Long rotate right: ac=0001, e=0, CIR shamt=15 -> busy 16 cycles, final ac=0002, e=0. op_valid CMA issued mid-rotate is ignored (ac unchanged by it).
- INC wrap and reset mid-op:
  - ac=FFFF, e=0, INC -> ac=0000, e=0, ac_zero=1.
  - Start CIR shamt=7, assert reset on the 3rd busy cycle -> ac=0000, e=0, busy=0, no done pulse.

Source files
------------

// File: rtl/ac_e_register.sv
// ac_e_register: accumulator/extension register with micro-ops and sequenced multi-step rotates
module ac_e_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_e,
  input  logic             load_alu,
  input  logic             ld_data,
  input  logic [WIDTH-1:0] data_in,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [3:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             ac_zero,
  output logic             ac_neg,
  output logic             e_zero
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       dir_left;
  assign busy    = state == SHIFT;
  assign ac_zero = ac == '0;
  assign ac_neg  = ac[WIDTH-1];
  assign e_zero  = !e;
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_left <= 1'b0;
      ac       <= '0;
      e        <= 1'b0;
      done     <= 1'b0;
    end else if (state == SHIFT) begin
      {e, ac} <= dir_left ? {ac, e} : {ac[0], e, ac[WIDTH-1:1]};
      done    <= cnt == '0;
      if (cnt == '0) state <= IDLE;
      else cnt <= cnt - 1'b1;
    end else begin
      done <= 1'b1;
      if (load_alu) begin
        ac <= alu_result;
        e  <= alu_e;
      end else if (ld_data) ac <= data_in;
      else if (op_valid)
        case (op)
          3'd0: ac <= '0;
          3'd1: e <= 1'b0;
          3'd2: ac <= ~ac;
          3'd3: e <= ~e;
          3'd4, 3'd5: begin
            state    <= SHIFT;
            cnt      <= shamt;
            dir_left <= op[0];
            done     <= 1'b0;
          end
          3'd6: ac <= ac + 1'b1;
          default: ;
        endcase
      else done <= 1'b0;
    end
endmodule
